// File: rtl/uart_dbg_pkg.sv
// Shared types for the debug UART scheduler: FSM state encoding and header channel mask.
package uart_dbg_pkg;

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        FETCH,
        START,
        WAIT_BUSY,
        WAIT_DONE
    } sched_state_t;

    localparam logic [7:0] HDR_CH_MASK = 8'h07;

    function automatic logic [7:0] hdr_byte(input logic [7:0] base, input logic [7:0] ch);
        return base | (ch & HDR_CH_MASK);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or after i_ptr, wrapping.
// Zero latency; no backpressure of its own.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_ptr,
    output logic [N-1:0]  o_grant,
    output logic [IW-1:0] o_idx,
    output logic          o_any
);

    logic [IW:0] w_pos;

    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        o_any   = 1'b0;
        w_pos   = '0;
        for (int k = 0; k < N; k++) begin
            w_pos = {1'b0, i_ptr} + (IW+1)'(k);
            if (w_pos >= (IW+1)'(N)) begin
                w_pos = w_pos - (IW+1)'(N);
            end
            if (!o_any && i_req[w_pos[IW-1:0]]) begin
                o_any                   = 1'b1;
                o_idx                   = w_pos[IW-1:0];
                o_grant[w_pos[IW-1:0]]  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_sched.sv
// Packet-granular round-robin scheduler sharing one uart_tx; IDLE->tx_start in 2 cycles with header.
// Requesters are only accepted in FETCH (req_ready to the owner); each byte waits for tx_busy to rise and fall.
module uart_tx_sched
    import uart_dbg_pkg::*;
#(
    parameter int         NUM_REQ     = 4,
    parameter int         HDR_EN      = 1,
    parameter logic [7:0] HDR_BASE    = 8'hA0,
    parameter int         MAX_PKT_LEN = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [NUM_REQ*8-1:0] req_data,
    input  logic [NUM_REQ-1:0]   req_last,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic [7:0]           tx_data_o,
    output logic                 tx_start_o,
    input  logic                 tx_busy_i,
    output logic [NUM_REQ-1:0]   grant_o,
    output logic                 pkt_done_o
);

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CW = (MAX_PKT_LEN > 0) ? $clog2(MAX_PKT_LEN + 1) : 1;

    sched_state_t       r_state, w_state_nx;
    logic [IW-1:0]      r_ptr, w_ptr_nx;
    logic [IW-1:0]      r_idx, w_idx_nx;
    logic [NUM_REQ-1:0] r_grant, w_grant_nx;
    logic [CW-1:0]      r_cnt, w_cnt_nx;
    logic               r_last, w_last_nx;
    logic               r_hdr, w_hdr_nx;
    logic [7:0]         r_data, w_data_nx;
    logic               r_done, w_done_nx;

    logic [NUM_REQ-1:0] w_arb_grant;
    logic [IW-1:0]      w_arb_idx;
    logic               w_arb_any;
    logic               w_cap;

    rr_arbiter #(.N(NUM_REQ), .IW(IW)) u_arb (
        .i_req   (req_valid),
        .i_ptr   (r_ptr),
        .o_grant (w_arb_grant),
        .o_idx   (w_arb_idx),
        .o_any   (w_arb_any)
    );

    // Forced release only limits one grant; the requester's packet carries on under the next grant.
    assign w_cap = (MAX_PKT_LEN != 0) && (r_cnt == CW'(MAX_PKT_LEN));

    always_comb begin
        w_state_nx = r_state;
        w_ptr_nx   = r_ptr;
        w_idx_nx   = r_idx;
        w_grant_nx = r_grant;
        w_cnt_nx   = r_cnt;
        w_last_nx  = r_last;
        w_hdr_nx   = r_hdr;
        w_data_nx  = r_data;
        w_done_nx  = 1'b0;
        req_ready  = '0;
        tx_start_o = 1'b0;
        case (r_state)
            IDLE: begin
                if (!tx_busy_i && w_arb_any) begin
                    w_grant_nx = w_arb_grant;
                    w_idx_nx   = w_arb_idx;
                    w_cnt_nx   = '0;
                    w_state_nx = (HDR_EN != 0) ? HDR : FETCH;
                end
            end
            HDR: begin
                w_data_nx  = hdr_byte(HDR_BASE, 8'(r_idx));
                w_hdr_nx   = 1'b1;
                w_state_nx = START;
            end
            FETCH: begin
                req_ready = r_grant;
                if (req_valid[r_idx]) begin
                    w_data_nx  = req_data[8*r_idx +: 8];
                    w_last_nx  = req_last[r_idx];
                    w_cnt_nx   = r_cnt + CW'(1);
                    w_hdr_nx   = 1'b0;
                    w_state_nx = START;
                end
            end
            START: begin
                tx_start_o = 1'b1;
                w_state_nx = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (tx_busy_i) begin
                    w_state_nx = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (!tx_busy_i) begin
                    if (!r_hdr && (r_last || w_cap)) begin
                        w_grant_nx = '0;
                        w_done_nx  = 1'b1;
                        w_ptr_nx   = (r_idx == IW'(NUM_REQ - 1)) ? '0 : r_idx + IW'(1);
                        w_state_nx = IDLE;
                    end else begin
                        w_state_nx = FETCH;
                    end
                end
            end
            default: w_state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_ptr   <= '0;
            r_idx   <= '0;
            r_grant <= '0;
            r_cnt   <= '0;
            r_last  <= 1'b0;
            r_hdr   <= 1'b0;
            r_data  <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_ptr   <= w_ptr_nx;
            r_idx   <= w_idx_nx;
            r_grant <= w_grant_nx;
            r_cnt   <= w_cnt_nx;
            r_last  <= w_last_nx;
            r_hdr   <= w_hdr_nx;
            r_data  <= w_data_nx;
            r_done  <= w_done_nx;
        end
    end

    assign tx_data_o  = r_data;
    assign grant_o    = r_grant;
    assign pkt_done_o = r_done;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Bench for uart_tx_sched: behavioural serializer, queue-fed requesters, packet-level reference model.
module tb_uart_tx_sched;

    localparam int NREQ     = 4;
    localparam int MAXL     = 2;
    localparam int BUSY_CYC = 40;   // 10 bit times at 4 baud ticks per bit

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_valid, req_last, req_ready, grant_o;
    logic [31:0] req_data;
    logic [7:0]  tx_data_o;
    logic        tx_start_o, tx_busy_i, pkt_done_o;

    always #5 clk = ~clk;

    uart_tx_sched #(
        .NUM_REQ(NREQ), .HDR_EN(1), .HDR_BASE(8'hA0), .MAX_PKT_LEN(MAXL)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_data(req_data), .req_last(req_last), .req_ready(req_ready),
        .tx_data_o(tx_data_o), .tx_start_o(tx_start_o), .tx_busy_i(tx_busy_i),
        .grant_o(grant_o), .pkt_done_o(pkt_done_o)
    );

    // Serializer stand-in and line monitor
    int         busy_cnt = 0;
    int         starts = 0, dones = 0, viol = 0;
    logic [7:0] obs[$];
    int         gq[$];
    logic [3:0] prev_grant = '0;

    assign tx_busy_i = (busy_cnt != 0);

    function automatic int oh_idx(input logic [3:0] v);
        int r = 0;
        for (int k = 0; k < NREQ; k++) if (v[k]) r = k;
        return r;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_cnt   <= 0;
            prev_grant <= '0;
        end else begin
            prev_grant <= grant_o;
            if (tx_start_o && busy_cnt == 0) begin
                obs.push_back(tx_data_o);
                busy_cnt <= BUSY_CYC;
            end else if (busy_cnt != 0) begin
                busy_cnt <= busy_cnt - 1;
            end
            if (tx_start_o) starts <= starts + 1;
            if (pkt_done_o) dones <= dones + 1;
            if (grant_o != 0 && prev_grant == 0) gq.push_back(oh_idx(grant_o));
            if ((tx_start_o && busy_cnt != 0) || $countones(grant_o) > 1) viol <= viol + 1;
        end
    end

    // Requester queues ({last, byte}), model copies, and bench state
    logic [8:0] rq[NREQ][$];
    logic [8:0] mq[NREQ][$];
    logic [3:0] en, hs;
    logic [7:0] exp_q[$];
    int         expg_q[$];
    int         mptr = 0;
    int         checks = 0, errors = 0;
    int         from, d0, s0, g0, n, nexp, np, len;
    logic [3:0] nib;
    logic [8:0] tmp;
    int         fexp[5] = '{0, 1, 0, 1, 0};

    typedef struct {
        logic [3:0]  mask;  // requesters each holding a one-byte packet
        logic [15:0] ord;   // expected grant order, first in top nibble, F = unused
    } cont_t;
    cont_t tbl[5];

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] expv);
        checks++;
        if (got !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, expv);
        end
    endtask

    task automatic chk_stream(input string name, input int base);
        int bad;
        logic [7:0] gb;
        bad = -1;
        gb  = '0;
        checks++;
        for (int k = 0; k < exp_q.size(); k++) begin
            if (bad < 0 && (base + k >= obs.size() || obs[base + k] !== exp_q[k])) bad = k;
        end
        if (bad < 0 && obs.size() - base != exp_q.size()) bad = exp_q.size();
        if (bad >= 0) begin
            errors++;
            if (base + bad < obs.size()) gb = obs[base + bad];
            $display("FAIL %s: byte %0d got %02h expected %02h (got %0d bytes, expected %0d)",
                     name, bad, gb, (bad < exp_q.size()) ? exp_q[bad] : 8'h00,
                     obs.size() - base, exp_q.size());
        end
    endtask

    task automatic put(input int r, input logic [7:0] b, input logic last);
        rq[r].push_back({last, b});
        mq[r].push_back({last, b});
    endtask

    task automatic drive();
        for (int i = 0; i < NREQ; i++) begin
            req_valid[i] = en[i] && (rq[i].size() > 0);
            req_data[8*i +: 8] = req_valid[i] ? rq[i][0][7:0] : 8'h00;
            req_last[i] = req_valid[i] ? rq[i][0][8] : 1'b0;
        end
    endtask

    // One clock: retire the handshakes seen just before the edge, drive, sample the next handshakes.
    task automatic cyc();
        @(posedge clk);
        #1;
        for (int i = 0; i < NREQ; i++) if (hs[i]) tmp = rq[i].pop_front();
        drive();
        #4;
        hs = req_valid & req_ready;
    endtask

    task automatic set_en(input logic [3:0] m);
        en = m;
        drive();
        #0;
        hs = req_valid & req_ready;
    endtask

    function automatic bit qs_empty();
        bit e = 1'b1;
        for (int i = 0; i < NREQ; i++) if (rq[i].size() != 0) e = 1'b0;
        return e;
    endfunction

    task automatic run_idle(input string name, input int budget);
        int c = 0;
        while (!(qs_empty() && grant_o == 0 && !tx_busy_i) && c < budget) begin
            cyc();
            c++;
        end
        if (c >= budget) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: still busy after %0d cycles, required idle", name, c);
        end
        repeat (3) cyc();
    endtask

    // Packet-level reference: strict RR from the pointer, one header per grant, at most MAXL bytes per grant.
    task automatic model_run();
        int g, cnt;
        logic [8:0] w;
        exp_q.delete();
        expg_q.delete();
        for (int it = 0; it < 512; it++) begin
            g = -1;
            for (int k = 0; k < NREQ; k++)
                if (g < 0 && mq[(mptr + k) % NREQ].size() > 0) g = (mptr + k) % NREQ;
            if (g < 0) break;
            exp_q.push_back(8'hA0 | 8'(g));
            expg_q.push_back(g);
            cnt = 0;
            w   = '0;
            while (!w[8] && cnt < MAXL && mq[g].size() > 0) begin
                w = mq[g].pop_front();
                exp_q.push_back(w[7:0]);
                cnt++;
            end
            mptr = (g + 1) % NREQ;
        end
    endtask

    initial begin
        tbl[0] = '{4'b1101, 16'h023F};
        tbl[1] = '{4'b0110, 16'h12FF};
        tbl[2] = '{4'b1011, 16'h301F};
        tbl[3] = '{4'b1111, 16'h2301};
        tbl[4] = '{4'b0001, 16'h0FFF};

        rst = 1'b1;
        en  = 4'hF;
        hs  = '0;
        req_valid = '0; req_data = '0; req_last = '0;
        repeat (3) cyc();
        chk("rst_tx_start", tx_start_o, 0);
        chk("rst_tx_data",  tx_data_o, 0);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_grant", grant_o, 0);
        chk("rst_pkt_done", pkt_done_o, 0);
        rst = 1'b0;
        cyc();

        // Contention table
        for (int t = 0; t < 5; t++) begin
            for (int i = 0; i < NREQ; i++) if (tbl[t].mask[i]) put(i, 8'hC0 | 8'(i), 1'b1);
            model_run();
            exp_q.delete();
            nexp = 0;
            for (int k = 0; k < 4; k++) begin
                nib = tbl[t].ord[15-4*k -: 4];
                if (nib != 4'hF) begin
                    exp_q.push_back(8'hA0 | {4'h0, nib});
                    exp_q.push_back(8'hC0 | {4'h0, nib});
                    nexp++;
                end
            end
            from = obs.size(); d0 = dones;
            run_idle($sformatf("cont%0d", t), 800);
            chk_stream($sformatf("cont%0d_stream", t), from);
            chk($sformatf("cont%0d_done", t), dones - d0, nexp);
        end

        // Single packet on req1
        put(1, 8'h55, 1'b0);
        put(1, 8'h0F, 1'b1);
        model_run();
        exp_q.delete();
        exp_q.push_back(8'hA1); exp_q.push_back(8'h55); exp_q.push_back(8'h0F);
        from = obs.size(); d0 = dones; s0 = starts;
        run_idle("single", 400);
        chk_stream("single_stream", from);
        chk("single_starts", starts - s0, 3);
        chk("single_done", dones - d0, 1);
        chk("single_grant_idle", grant_o, 0);

        // Fairness: req0 back-to-back packets against req1
        for (int p = 0; p < 3; p++) begin
            put(0, 8'(8'h01 + 2*p), 1'b0);
            put(0, 8'(8'h02 + 2*p), 1'b1);
        end
        for (int p = 0; p < 2; p++) begin
            put(1, 8'(8'h11 + 2*p), 1'b0);
            put(1, 8'(8'h12 + 2*p), 1'b1);
        end
        model_run();
        from = obs.size(); g0 = gq.size();
        run_idle("fair", 1500);
        chk_stream("fair_stream", from);
        chk("fair_ngrants", gq.size() - g0, 5);
        for (int k = 0; k < 5; k++)
            if (g0 + k < gq.size()) chk($sformatf("fair_grant%0d", k), gq[g0 + k], fexp[k]);

        // Forced release at MAX_PKT_LEN
        for (int b = 0; b < 5; b++) put(2, 8'(8'hB0 + b), b == 4);
        model_run();
        exp_q.delete();
        exp_q.push_back(8'hA2); exp_q.push_back(8'hB0); exp_q.push_back(8'hB1);
        exp_q.push_back(8'hA2); exp_q.push_back(8'hB2); exp_q.push_back(8'hB3);
        exp_q.push_back(8'hA2); exp_q.push_back(8'hB4);
        from = obs.size(); d0 = dones;
        run_idle("maxlen", 1000);
        chk_stream("maxlen_stream", from);
        chk("maxlen_done", dones - d0, 3);

        // FETCH stall on req3 while req0 waits
        put(3, 8'hD0, 1'b0); put(3, 8'hD1, 1'b0); put(3, 8'hD2, 1'b1);
        put(0, 8'hE0, 1'b1);
        model_run();
        from = obs.size(); g0 = gq.size();
        n = 0;
        while (rq[3].size() != 2 && n < 300) begin cyc(); n++; end
        chk("stall_first_byte_taken", rq[3].size(), 2);
        set_en(4'b0111);
        repeat (50) cyc();
        s0 = starts;
        repeat (40) cyc();
        chk("stall_no_start", starts - s0, 0);
        chk("stall_grant_held", grant_o, 4'b1000);
        chk("stall_ready", req_ready, 4'b1000);
        chk("stall_no_other_grant", gq.size() - g0, 1);
        set_en(4'hF);
        run_idle("stall", 800);
        chk_stream("stall_stream", from);

        // Reset while the payload byte is on the wire
        put(1, 8'h77, 1'b0);
        put(1, 8'h78, 1'b1);
        from = obs.size();
        n = 0;
        while (obs.size() < from + 2 && n < 300) begin cyc(); n++; end
        chk("rst_mid_reached", obs.size() - from, 2);
        repeat (10) cyc();
        rst = 1'b1;
        #1;
        chk("rstmid_tx_start", tx_start_o, 0);
        chk("rstmid_tx_data", tx_data_o, 0);
        chk("rstmid_req_ready", req_ready, 0);
        chk("rstmid_grant", grant_o, 0);
        chk("rstmid_pkt_done", pkt_done_o, 0);
        hs = '0;
        repeat (2) cyc();
        rst = 1'b0;
        for (int i = 0; i < NREQ; i++) mq[i] = rq[i];
        mptr = 0;
        model_run();
        from = obs.size();
        run_idle("rstmid", 400);
        chk_stream("rstmid_fresh_hdr", from);

        // Randomized rounds against the reference model
        for (int rd = 0; rd < 4; rd++) begin
            for (int i = 0; i < NREQ; i++) begin
                if ($urandom_range(0, 2) != 0 || i == rd) begin
                    np = $urandom_range(1, 2);
                    for (int p = 0; p < np; p++) begin
                        len = $urandom_range(1, 5);
                        for (int b = 0; b < len; b++) put(i, 8'($urandom), b == len - 1);
                    end
                end
            end
            model_run();
            from = obs.size(); d0 = dones;
            run_idle($sformatf("rand%0d", rd), 6000);
            chk_stream($sformatf("rand%0d_stream", rd), from);
            chk($sformatf("rand%0d_done", rd), dones - d0, expg_q.size());
        end

        chk("protocol_violations", viol, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
